monitor_event_arbiter: RTL and testbench

MONITOR_EVENT_ARBITER -- requirements
Module: monitor_event_arbiter

---
 rtl/monitor_event_arbiter.sv | 133 +++++++++++++
 tb/tb_monitor_event_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/monitor_event_arbiter.sv
// Round-robin arbiter that serialises device connect/disconnect events into a
// single change/on_off pulse stream, keeping a saturating shadow of the count.
module monitor_event_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] req_on,
    output logic [N_REQ-1:0] ack,
    output logic             nack,
    output logic             change,
    output logic             on_off,
    output logic             busy,
    output logic [CNT_W-1:0] shadow_cnt
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               nack_q, nack_d;
    logic               change_q, change_d;
    logic               on_off_q, on_off_d;

    logic               found;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   ptr_next;

    // Round-robin search: first asserted request at or after ptr, wrapping.
    always_comb begin : search
        int             idx;
        logic [PTR_W-1:0] idx_p;
        found     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        idx_p     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            idx_p = PTR_W'(idx);
            if (!found && req[idx_p]) begin
                found     = 1'b1;
                grant_idx = idx_p;
            end
        end
    end

    assign ptr_next = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        ack_d    = '0;
        nack_d   = 1'b0;
        change_d = 1'b0;
        on_off_d = on_off_q;

        case (state_q)
            IDLE: begin
                if (en && found) begin
                    state_d          = ISSUE;
                    ptr_d            = ptr_next;
                    ack_d[grant_idx] = 1'b1;
                    // The event is resolved at the grant edge so ISSUE shows the result.
                    if (req_on[grant_idx]) begin
                        if (cnt_q != CNT_MAX) begin
                            cnt_d    = cnt_q + CNT_W'(1);
                            change_d = 1'b1;
                            on_off_d = 1'b1;
                        end else begin
                            nack_d = 1'b1;
                        end
                    end else begin
                        if (cnt_q != '0) begin
                            cnt_d    = cnt_q - CNT_W'(1);
                            change_d = 1'b1;
                            on_off_d = 1'b0;
                        end else begin
                            nack_d = 1'b1;
                        end
                    end
                end
            end
            ISSUE: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            ack_q    <= '0;
            nack_q   <= 1'b0;
            change_q <= 1'b0;
            on_off_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            nack_q   <= nack_d;
            change_q <= change_d;
            on_off_q <= on_off_d;
        end
    end

    assign ack        = ack_q;
    assign nack       = nack_q;
    assign change     = change_q;
    assign on_off     = on_off_q;
    assign busy       = (state_q == ISSUE);
    assign shadow_cnt = cnt_q;

endmodule

// File: tb/tb_monitor_event_arbiter.sv
// Self-checking bench for monitor_event_arbiter: directed vector table, corner
// sequences, and biased random traffic against a behavioural model.
module tb_monitor_event_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int CMAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [N-1:0] req;
    logic [N-1:0] req_on;
    logic [N-1:0] ack;
    logic         nack;
    logic         change;
    logic         on_off;
    logic         busy;
    logic [W-1:0] shadow_cnt;

    always #5 clk = ~clk;

    monitor_event_arbiter #(.N_REQ(N), .CNT_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req        (req),
        .req_on     (req_on),
        .ack        (ack),
        .nack       (nack),
        .change     (change),
        .on_off     (on_off),
        .busy       (busy),
        .shadow_cnt (shadow_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural reference: outputs expected after each clock edge.
    int           m_cnt    = 0;
    int           m_ptr    = 0;
    bit           m_busy   = 1'b0;
    logic [N-1:0] m_ack    = '0;
    bit           m_nack   = 1'b0;
    bit           m_change = 1'b0;
    bit           m_on_off = 1'b0;

    typedef struct {
        logic         r;
        logic         e;
        logic [N-1:0] rq;
        logic [N-1:0] on;
        logic [N-1:0] x_ack;
        logic         x_nack;
        logic         x_chg;
        logic         x_onoff;
        logic         x_busy;
        logic [W-1:0] x_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [N-1:0] x_ack, input logic x_nack,
                              input logic x_chg, input logic x_onoff, input logic x_busy,
                              input logic [W-1:0] x_cnt);
        check({tag, " ack"},        32'(ack),        32'(x_ack));
        check({tag, " nack"},       32'(nack),       32'(x_nack));
        check({tag, " change"},     32'(change),     32'(x_chg));
        check({tag, " on_off"},     32'(on_off),     32'(x_onoff));
        check({tag, " busy"},       32'(busy),       32'(x_busy));
        check({tag, " shadow_cnt"}, 32'(shadow_cnt), 32'(x_cnt));
    endtask

    task automatic model_edge(input logic r, input logic e, input logic [N-1:0] rq,
                              input logic [N-1:0] on);
        bit got;
        int g;
        got = 1'b0;
        g   = 0;
        if (r !== 1'b1) begin
            m_busy = 0; m_ptr = 0; m_cnt = 0;
            m_ack = '0; m_nack = 0; m_change = 0; m_on_off = 0;
        end else if (m_busy) begin
            m_busy = 0; m_ack = '0; m_nack = 0; m_change = 0;
        end else if (e === 1'b1 && rq != '0) begin
            for (int k = 0; k < N; k++) begin
                if (!got && rq[(m_ptr + k) % N] === 1'b1) begin
                    got = 1'b1;
                    g   = (m_ptr + k) % N;
                end
            end
            m_busy   = 1;
            m_ack    = N'(1) << g;
            m_ptr    = (g + 1) % N;
            m_change = 0;
            m_nack   = 1;
            if (on[g] === 1'b1 && m_cnt < CMAX) begin
                m_cnt++; m_change = 1; m_nack = 0; m_on_off = 1;
            end else if (on[g] === 1'b0 && m_cnt > 0) begin
                m_cnt--; m_change = 1; m_nack = 0; m_on_off = 0;
            end
        end else begin
            m_ack = '0; m_nack = 0; m_change = 0;
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [N-1:0] rq, input logic [N-1:0] on);
        rst    = r;
        en     = e;
        req    = rq;
        req_on = on;
        @(posedge clk);
        model_edge(r, e, rq, on);
        #1;
    endtask

    task automatic check_model(input string tag);
        check_outs(tag, m_ack, m_nack, m_change, m_on_off, m_busy, W'(m_cnt));
    endtask

    task automatic add(input logic r, input logic e, input logic [N-1:0] rq, input logic [N-1:0] on,
                       input logic [N-1:0] x_ack, input logic x_nack, input logic x_chg,
                       input logic x_onoff, input logic x_busy, input logic [W-1:0] x_cnt);
        vec_t v;
        v = '{r, e, rq, on, x_ack, x_nack, x_chg, x_onoff, x_busy, x_cnt};
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; req = '0; req_on = '0;

        // Reset with all requests raised, then three single connects.
        add(0, 1, 4'b1111, 4'b1111, 4'b0000, 0, 0, 0, 0, 0);
        add(0, 1, 4'b1111, 4'b1111, 4'b0000, 0, 0, 0, 0, 0);
        add(1, 1, 4'b0001, 4'b0001, 4'b0001, 0, 1, 1, 1, 1);
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 0, 1);
        add(1, 1, 4'b0001, 4'b0001, 4'b0001, 0, 1, 1, 1, 2);
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 0, 2);
        add(1, 1, 4'b0001, 4'b0001, 4'b0001, 0, 1, 1, 1, 3);
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 0, 3);
        // Round-robin over four held connect requests.
        add(0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        add(1, 1, 4'b1111, 4'b1111, 4'b0001, 0, 1, 1, 1, 1);
        add(1, 1, 4'b1111, 4'b1111, 4'b0000, 0, 0, 1, 0, 1);
        add(1, 1, 4'b1111, 4'b1111, 4'b0010, 0, 1, 1, 1, 2);
        add(1, 1, 4'b1111, 4'b1111, 4'b0000, 0, 0, 1, 0, 2);
        add(1, 1, 4'b1111, 4'b1111, 4'b0100, 0, 1, 1, 1, 3);
        add(1, 1, 4'b1111, 4'b1111, 4'b0000, 0, 0, 1, 0, 3);
        add(1, 1, 4'b1111, 4'b1111, 4'b1000, 0, 1, 1, 1, 4);
        add(1, 1, 4'b1111, 4'b1111, 4'b0000, 0, 0, 1, 0, 4);
        add(1, 1, 4'b1111, 4'b1111, 4'b0001, 0, 1, 1, 1, 5);
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1, 0, 5);
        // Underflow: disconnect at zero is rejected.
        add(0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        add(1, 1, 4'b0100, 4'b0000, 4'b0100, 1, 0, 0, 1, 0);
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].e, vecs[i].rq, vecs[i].on);
            check_outs($sformatf("vec%0d", i), vecs[i].x_ack, vecs[i].x_nack, vecs[i].x_chg,
                       vecs[i].x_onoff, vecs[i].x_busy, vecs[i].x_cnt);
        end

        // Overflow: saturate at the maximum, then step back down once.
        step(0, 1, 4'b0000, 4'b0000);
        for (int i = 0; i < CMAX; i++) begin
            step(1, 1, 4'b0001, 4'b0001);
            step(1, 1, 4'b0000, 4'b0000);
        end
        check_outs("ovf_full", 4'b0000, 0, 0, 1, 0, 8'd255);
        step(1, 1, 4'b0001, 4'b0001);
        check_outs("ovf_reject", 4'b0001, 1, 0, 1, 1, 8'd255);
        step(1, 1, 4'b0000, 4'b0000);
        step(1, 1, 4'b0001, 4'b0000);
        check_outs("ovf_down", 4'b0001, 0, 1, 0, 1, 8'd254);

        // Enable gating, unknown requests while disabled, and reset mid-ISSUE.
        step(0, 1, 4'b0000, 4'b0000);
        step(1, 0, 4'bxxxx, 4'bxxxx);
        check_outs("en0_x", 4'b0000, 0, 0, 0, 0, 8'd0);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 4'b0010, 4'b0010);
            check_outs($sformatf("en0_%0d", i), 4'b0000, 0, 0, 0, 0, 8'd0);
        end
        step(1, 1, 4'b0010, 4'b0010);
        check_outs("en1_grant", 4'b0010, 0, 1, 1, 1, 8'd1);
        step(1, 0, 4'b0010, 4'b0010);
        check_outs("en_fall_done", 4'b0000, 0, 0, 1, 0, 8'd1);
        step(1, 1, 4'b0010, 4'b0010);
        check_outs("regrant", 4'b0010, 0, 1, 1, 1, 8'd2);
        step(0, 1, 4'b0010, 4'b0010);
        check_outs("rst_in_issue", 4'b0000, 0, 0, 0, 0, 8'd0);
        step(1, 0, 4'b0000, 4'b0000);
        check_outs("after_rst", 4'b0000, 0, 0, 0, 0, 8'd0);

        // Biased random traffic: alternating connect-heavy and disconnect-heavy phases.
        for (int i = 0; i < 6000; i++) begin
            logic         rr;
            logic         ee;
            logic [N-1:0] rq;
            logic [N-1:0] on;
            int           bias;
            bias = ((i / 1500) % 2 == 0) ? 85 : 15;
            rr   = ($urandom_range(0, 1999) == 0) ? 1'b0 : 1'b1;
            ee   = ($urandom_range(0, 9) != 0);
            rq   = N'($urandom);
            for (int b = 0; b < N; b++) begin
                on[b] = ($urandom_range(0, 99) < bias);
            end
            step(rr, ee, rq, on);
            check_model($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
